// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and the arctangent table for the cosine sequencer.
package cordic_pkg;

  localparam int FRAC_W = 21;
  localparam int GUARD  = 2;
  localparam int IW     = FRAC_W + 1 + GUARD;
  localparam int ATAN_N = 21;
  localparam int ATAN_IW = $clog2(ATAN_N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_ITER,
    ST_PACK
  } cordicState_e;

  // round(0.6072529350 * 2^21): pre-scales x so the CORDIC gain cancels out.
  localparam logic signed [IW-1:0] K_INIT    = 24'sd1273502;
  localparam logic signed [IW-1:0] ANGLE_ONE = 24'sd2097152;

  // ATAN[i] = round(atan(2^-i) * 2^21)
  localparam logic signed [IW-1:0] ATAN [ATAN_N] = '{
    24'sd1647099, 24'sd972340, 24'sd513757, 24'sd260791, 24'sd130902,
    24'sd65515,   24'sd32765,  24'sd16384,  24'sd8192,   24'sd4096,
    24'sd2048,    24'sd1024,   24'sd512,    24'sd256,    24'sd128,
    24'sd64,      24'sd32,     24'sd16,     24'sd8,      24'sd4,
    24'sd2
  };

  // Keeps the rotation inside the +/-1 rad range the table converges over.
  function automatic logic signed [IW-1:0] satAngle(input logic signed [IW-1:0] a);
    if (a > ANGLE_ONE) return ANGLE_ONE;
    else if (a < -ANGLE_ONE) return -ANGLE_ONE;
    else return a;
  endfunction

endpackage

// File: rtl/fixed_to_float.sv
// Unsigned Q1.21 to IEEE-754 single packer; exact because the input has fewer bits than the mantissa.
module fixed_to_float
  import cordic_pkg::*;
(
  input  logic [FRAC_W:0] ufixedPoint,
  output logic [31:0]     floatingPoint
);

  localparam int MSB_W = $clog2(FRAC_W + 1);

  logic [MSB_W-1:0] msbPos;
  logic [FRAC_W:0]  normVal;
  logic [7:0]       expField;

  // Leading-one search; the ascending loop leaves the highest set bit in msbPos.
  always_comb begin
    msbPos = '0;
    for (int i = 0; i <= FRAC_W; i++) begin
      if (ufixedPoint[i]) msbPos = i[MSB_W-1:0];
    end
  end

  // Normalise so the hidden one lands on the top bit, then assemble the fields.
  always_comb begin
    normVal  = ufixedPoint << (MSB_W'(FRAC_W) - msbPos);
    expField = 8'(127 - FRAC_W) + 8'(msbPos);
    if (ufixedPoint == '0) floatingPoint = 32'h0;
    else floatingPoint = {1'b0, expField, normVal[FRAC_W-1:0], 2'b00};
  end

endmodule

// File: rtl/cordic_cos_sequencer.sv
// Custom-instruction sequencer computing cos(angle) on one iterative CORDIC datapath.
//
// state   | meaning
// ST_IDLE | waiting for start; result/done from the last request visible
// ST_INIT | load x=K, y=0, z=angle, step=0
// ST_ITER | one micro-rotation per enabled cycle, ITER in total
// ST_PACK | clamp x, capture packed float, pulse done
module cordic_cos_sequencer
  import cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic        busy,
  output logic [31:0] result
);

  localparam int STEP_W = $clog2(ITER);

  cordicState_e state, nextState;

  logic signed [IW-1:0] xReg, yReg, zReg, angleReg;
  logic signed [IW-1:0] angleIn, xShift, yShift, xNext, yNext, zNext;
  logic [STEP_W-1:0]    stepCnt;
  logic [ATAN_IW-1:0]   atanIdx;
  logic                 dirPos, lastStep;
  logic                 doneReg, busyReg;
  logic [31:0]          resultReg, packedFloat;
  logic [FRAC_W:0]      xClamp;
  logic                 unusedDataa;

  assign unusedDataa = ^dataa[31:FRAC_W+1];
  assign angleIn     = {{GUARD{dataa[FRAC_W]}}, dataa[FRAC_W:0]};
  assign lastStep    = (stepCnt == STEP_W'(ITER - 1));
  assign atanIdx     = ATAN_IW'(stepCnt);

  // Next-state decode; every transition is qualified by clk_en in the register.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (start) nextState = ST_INIT;
      ST_INIT: nextState = ST_ITER;
      ST_ITER: if (lastStep) nextState = ST_PACK;
      ST_PACK: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // State register with synchronous reset that ignores clk_en.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else if (clk_en) state <= nextState;
  end

  // One rotation-mode micro-step: rotate towards z = 0.
  always_comb begin
    dirPos = ~zReg[IW-1];
    xShift = xReg >>> stepCnt;
    yShift = yReg >>> stepCnt;
    xNext  = dirPos ? (xReg - yShift) : (xReg + yShift);
    yNext  = dirPos ? (yReg + xShift) : (yReg - xShift);
    zNext  = dirPos ? (zReg - ATAN[atanIdx]) : (zReg + ATAN[atanIdx]);
  end

  // Small negative residues and gain overshoot are clipped to the packer's [0, 1.0] range.
  always_comb begin
    if (xReg[IW-1]) xClamp = '0;
    else if (xReg > ANGLE_ONE) xClamp = ANGLE_ONE[FRAC_W:0];
    else xClamp = xReg[FRAC_W:0];
  end

  fixed_to_float uPacker (
    .ufixedPoint   (xClamp),
    .floatingPoint (packedFloat)
  );

  // Datapath and output registers, advanced per state on enabled edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      xReg      <= '0;
      yReg      <= '0;
      zReg      <= '0;
      angleReg  <= '0;
      stepCnt   <= '0;
      doneReg   <= 1'b0;
      busyReg   <= 1'b0;
      resultReg <= '0;
    end else if (clk_en) begin
      doneReg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            angleReg <= satAngle(angleIn);
            busyReg  <= 1'b1;
          end
        end
        ST_INIT: begin
          xReg    <= K_INIT;
          yReg    <= '0;
          zReg    <= angleReg;
          stepCnt <= '0;
        end
        ST_ITER: begin
          xReg    <= xNext;
          yReg    <= yNext;
          zReg    <= zNext;
          stepCnt <= stepCnt + STEP_W'(1);
        end
        ST_PACK: begin
          resultReg <= packedFloat;
          doneReg   <= 1'b1;
          busyReg   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign done   = doneReg;
  assign busy   = busyReg;
  assign result = resultReg;

endmodule

// File: tb/tb_cordic_cos_sequencer.sv
// Directed bench for cordic_cos_sequencer: latency, handshake, clk_en stalls, reset and cos accuracy.
module tb_cordic_cos_sequencer;

  // 16 micro-rotations leave up to atan(2^-15) of residual angle, plus a few LSBs of truncation.
  localparam real TOL = 1.0 / 16384.0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic        busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [21:0] angle;
    int          expCosE7;
  } vec_t;

  vec_t vecs [12];

  cordic_cos_sequencer #(.ITER(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .done    (done),
    .busy    (busy),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real m;
    if (b[30:0] == 31'h0) return 0.0;
    e = int'(b[30:23]);
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    if (b[31]) m = -m;
    return m * (2.0 ** (e - 127));
  endfunction

  task automatic checkEq(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic checkCos(input string name, input logic [31:0] bits, input real req);
    real got;
    got = f2r(bits);
    checks++;
    if ((got - req > TOL) || (req - got > TOL)) begin
      failures++;
      $display("FAIL %s: got %h (%0.7f) required %0.7f +/- %0.7f", name, bits, got, req, TOL);
    end
  endtask

  // Issues one request and steps until done, up to a fixed budget.
  // seqOk collects handshake rules: busy right after acceptance, busy held until done,
  // busy low with done, and nothing moving on edges with clk_en=0.
  task automatic runReq(input logic [21:0] ang, input bit toggleEn, input int restartEdge,
                        output int lat, output logic [31:0] res, output bit seqOk);
    int          e;
    logic [31:0] pRes;
    logic        pDone, pBusy;
    dataa  = {10'h2A5, ang};
    start  = 1'b1;
    clk_en = 1'b1;
    tick();
    start = 1'b0;
    seqOk = busy && !done;
    lat   = -1;
    e     = 0;
    while (lat < 0 && e < 400) begin
      e++;
      clk_en = toggleEn ? (e % 2 == 0) : 1'b1;
      if (e == restartEdge) begin
        start = 1'b1;
        dataa = {10'h15A, 22'h3E0000};
      end
      pRes  = result;
      pDone = done;
      pBusy = busy;
      tick();
      start = 1'b0;
      if (!clk_en && (result != pRes || done != pDone || busy != pBusy)) seqOk = 1'b0;
      if (done) lat = e;
      else if (!busy) seqOk = 1'b0;
    end
    if (busy) seqOk = 1'b0;
    res = result;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    bit          ok;
    bit          stray;
    int          a;

    vecs[0]  = '{22'h000000, 10000000};
    vecs[1]  = '{22'h1FFFFF, 5403027};
    vecs[2]  = '{22'h200000, 5403023};
    vecs[3]  = '{22'h100000, 8775826};
    vecs[4]  = '{22'h300000, 8775826};
    vecs[5]  = '{22'h080000, 9689124};
    vecs[6]  = '{22'h3C0000, 9921977};
    vecs[7]  = '{22'h180000, 7316889};
    vecs[8]  = '{22'h0CCCCD, 9210610};
    vecs[9]  = '{22'h3E0000, 9980475};
    vecs[10] = '{22'h000001, 10000000};
    vecs[11] = '{22'h2CCCCD, 8253356};

    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b1;
    dataa   = 32'h0010_0000;
    repeat (3) tick();
    checkEq("rst_done", done, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_result", result, 0);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    checkEq("rst_no_accept_busy", busy, 0);
    checkEq("rst_no_accept_done", done, 0);

    // Directed table, clk_en held high.
    for (int i = 0; i < 12; i++) begin
      runReq(vecs[i].angle, 1'b0, -1, lat, res, ok);
      checkEq($sformatf("vec%0d_latency", i), lat, 18);
      checkEq($sformatf("vec%0d_handshake", i), ok, 1);
      checkCos($sformatf("vec%0d_cos", i), res, real'(vecs[i].expCosE7) / 1.0e7);
      if (vecs[i].angle == 22'h0) checkEq($sformatf("vec%0d_le_one", i), res > 32'h3F800000, 0);
      clk_en = 1'b1;
      tick();
      checkEq($sformatf("vec%0d_done_width", i), done, 0);
    end

    // Sweep from -1.0 to just under +1.0 against a real cosine.
    for (int k = 0; k < 64; k++) begin
      a = -2097152 + k * 66576;
      runReq(22'(a), 1'b0, -1, lat, res, ok);
      checkEq($sformatf("sweep%0d_latency", k), lat, 18);
      checkCos($sformatf("sweep%0d_cos", k), res, $cos(real'(a) / 2097152.0));
      clk_en = 1'b1;
      tick();
      checkEq($sformatf("sweep%0d_done_width", k), done, 0);
    end

    // clk_en alternating: latency doubles, outputs frozen on disabled edges.
    runReq(22'h200000, 1'b1, -1, lat, res, ok);
    checkEq("toggle_latency", lat, 36);
    checkEq("toggle_handshake", ok, 1);
    checkCos("toggle_cos", res, 0.5403023);
    clk_en = 1'b0;
    tick();
    checkEq("toggle_done_held", done, 1);
    checkEq("toggle_result_held", result, res);
    clk_en = 1'b1;
    tick();
    checkEq("toggle_done_cleared", done, 0);

    // Start re-pulsed while busy must not disturb the request or queue another.
    runReq(22'h100000, 1'b0, 5, lat, res, ok);
    checkEq("restart_latency", lat, 18);
    checkEq("restart_handshake", ok, 1);
    checkCos("restart_cos", res, 0.8775826);
    stray = 1'b0;
    repeat (25) begin
      tick();
      if (busy || done) stray = 1'b1;
    end
    checkEq("restart_no_second_request", stray, 0);

    // Reset at edge 9 of a request, with clk_en low on that edge.
    dataa  = {10'h0, 22'h080000};
    start  = 1'b1;
    clk_en = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    reset_n = 1'b0;
    clk_en  = 1'b0;
    tick();
    reset_n = 1'b1;
    clk_en  = 1'b1;
    checkEq("midrst_done", done, 0);
    checkEq("midrst_busy", busy, 0);
    checkEq("midrst_result", result, 0);
    stray = 1'b0;
    repeat (25) begin
      tick();
      if (busy || done) stray = 1'b1;
    end
    checkEq("midrst_no_done", stray, 0);
    runReq(22'h300000, 1'b0, -1, lat, res, ok);
    checkEq("postrst_latency", lat, 18);
    checkEq("postrst_handshake", ok, 1);
    checkCos("postrst_cos", res, 0.8775826);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
